// File: rtl/keypad_code_entry_if.sv
// Button inputs and lock indicator outputs of the keypad code entry block.
// The bench drives the master side; the design takes the slave side.
interface keypad_code_entry_if;
   logic       btn1;
   logic       btn2;
   logic       btn3;
   logic       unlock;
   logic       alarm;
   logic [6:0] seg;

   modport master (
      output btn1, btn2, btn3,
      input  unlock, alarm, seg
   );

   modport slave (
      input  btn1, btn2, btn3,
      output unlock, alarm, seg
   );
endinterface

// File: rtl/keypad_code_entry.sv
// Keypad code entry: synchronises and debounces three active-low buttons, collects a
// 4-symbol sequence, checks it against CODE and drives unlock/alarm/7-seg with lockout.
module keypad_code_entry #(
   parameter int         DEBOUNCE_CYCLES = 1_000_000,
   parameter int         TICK_CYCLES     = 50_000_000,
   parameter logic [7:0] CODE            = 8'b01_10_11_01,
   parameter int         MAX_FAIL        = 3,
   parameter int         OPEN_S          = 5,
   parameter int         LOCKOUT_S       = 9,
   parameter int         TIMEOUT_S       = 4
) (
   input logic                clk,
   input logic                rst_n,
   keypad_code_entry_if.slave keys
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TK_W = $clog2(TICK_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ENTRY,
      S_CHECK,
      S_FAIL,
      S_OPEN,
      S_LOCKOUT
   } state_t;

   logic [2:0] raw;
   logic [2:0] press;

   assign raw = {keys.btn3, keys.btn2, keys.btn1};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_btn
         logic            meta_reg;
         logic            sync_reg;
         logic            level_reg;
         logic            level_prev_reg;
         logic            armed_reg;
         logic [DB_W-1:0] db_cnt_reg;
         logic [DB_W-1:0] rel_cnt_reg;

         // armed_reg stays low until the button has been seen released for a full
         // debounce window, so a button held through reset cannot create a press.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               meta_reg       <= 1'b1;
               sync_reg       <= 1'b1;
               level_reg      <= 1'b1;
               level_prev_reg <= 1'b1;
               armed_reg      <= 1'b0;
               db_cnt_reg     <= '0;
               rel_cnt_reg    <= '0;
            end else begin
               meta_reg       <= raw[gi];
               sync_reg       <= meta_reg;
               level_prev_reg <= level_reg;
               if (sync_reg != level_reg) begin
                  if (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                     level_reg  <= sync_reg;
                     db_cnt_reg <= '0;
                  end else begin
                     db_cnt_reg <= db_cnt_reg + 1'b1;
                  end
               end else begin
                  db_cnt_reg <= '0;
               end
               if (!armed_reg) begin
                  if (!sync_reg) begin
                     rel_cnt_reg <= '0;
                  end else if (rel_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                     armed_reg <= 1'b1;
                  end else begin
                     rel_cnt_reg <= rel_cnt_reg + 1'b1;
                  end
               end
            end
         end

         assign press[gi] = armed_reg & level_prev_reg & ~level_reg;
      end
   endgenerate

   state_t          state_reg, state_next;
   logic [2:0]      count_reg, count_next;
   logic [3:0]      sec_reg, sec_next;
   logic [2:0]      fail_cnt_reg, fail_cnt_next;
   logic [7:0]      code_reg, code_next;
   logic [TK_W-1:0] tick_cnt_reg;
   logic [6:0]      seg_reg;
   logic            unlock_reg;
   logic            alarm_reg;
   logic            tick;
   logic            tick_restart;
   logic            accept;
   logic [1:0]      sym;

   assign tick   = (tick_cnt_reg == TK_W'(TICK_CYCLES - 1));
   assign accept = $onehot(press) && (state_reg == S_IDLE || state_reg == S_ENTRY);
   assign sym    = press[2] ? 2'd3 : (press[1] ? 2'd2 : 2'd1);

   function automatic logic [6:0] seven_seg(input logic [3:0] digit);
      logic [6:0] pattern;
      case (digit)
         4'd0:    pattern = 7'b1000000;
         4'd1:    pattern = 7'b1111001;
         4'd2:    pattern = 7'b0100100;
         4'd3:    pattern = 7'b0110000;
         4'd4:    pattern = 7'b0011001;
         4'd5:    pattern = 7'b0010010;
         4'd6:    pattern = 7'b0000010;
         4'd7:    pattern = 7'b1111000;
         4'd8:    pattern = 7'b0000000;
         4'd9:    pattern = 7'b0010000;
         default: pattern = 7'b1111111;
      endcase
      return pattern;
   endfunction

   // sec_reg doubles as the inter-press timeout counter while in ENTRY.
   always_comb begin
      state_next    = state_reg;
      count_next    = count_reg;
      sec_next      = sec_reg;
      fail_cnt_next = fail_cnt_reg;
      code_next     = code_reg;
      tick_restart  = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (accept) begin
               code_next    = {code_reg[5:0], sym};
               count_next   = 3'd1;
               sec_next     = 4'(TIMEOUT_S);
               tick_restart = 1'b1;
               state_next   = S_ENTRY;
            end
         end
         S_ENTRY: begin
            if (accept) begin
               code_next    = {code_reg[5:0], sym};
               count_next   = count_reg + 3'd1;
               sec_next     = 4'(TIMEOUT_S);
               tick_restart = 1'b1;
               if (count_reg == 3'd3) begin
                  state_next = S_CHECK;
               end
            end else if (tick) begin
               if (sec_reg == 4'd1) begin
                  count_next = 3'd0;
                  sec_next   = 4'd0;
                  state_next = S_IDLE;
               end else begin
                  sec_next = sec_reg - 4'd1;
               end
            end
         end
         S_CHECK: begin
            count_next = 3'd0;
            if (code_reg == CODE) begin
               fail_cnt_next = 3'd0;
               sec_next      = 4'(OPEN_S);
               tick_restart  = 1'b1;
               state_next    = S_OPEN;
            end else begin
               state_next = S_FAIL;
            end
         end
         S_FAIL: begin
            count_next    = 3'd0;
            fail_cnt_next = fail_cnt_reg + 3'd1;
            if (fail_cnt_reg == 3'(MAX_FAIL - 1)) begin
               sec_next     = 4'(LOCKOUT_S);
               tick_restart = 1'b1;
               state_next   = S_LOCKOUT;
            end else begin
               state_next = S_IDLE;
            end
         end
         S_OPEN: begin
            if (tick) begin
               sec_next = sec_reg - 4'd1;
               if (sec_reg == 4'd1) begin
                  state_next = S_IDLE;
               end
            end
         end
         S_LOCKOUT: begin
            if (tick) begin
               sec_next = sec_reg - 4'd1;
               if (sec_reg == 4'd1) begin
                  fail_cnt_next = 3'd0;
                  state_next    = S_IDLE;
               end
            end
         end
         default: begin
            count_next = 3'd0;
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= S_IDLE;
         count_reg    <= 3'd0;
         sec_reg      <= 4'd0;
         fail_cnt_reg <= 3'd0;
         code_reg     <= 8'd0;
         unlock_reg   <= 1'b0;
         alarm_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         count_reg    <= count_next;
         sec_reg      <= sec_next;
         fail_cnt_reg <= fail_cnt_next;
         code_reg     <= code_next;
         unlock_reg   <= (state_next == S_OPEN);
         alarm_reg    <= (state_next == S_LOCKOUT);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick_cnt_reg <= '0;
      end else if (tick_restart || tick) begin
         tick_cnt_reg <= '0;
      end else begin
         tick_cnt_reg <= tick_cnt_reg + 1'b1;
      end
   end

   // The display holds its last value through the one-cycle CHECK and FAIL states.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_reg <= 7'b1000000;
      end else begin
         case (state_reg)
            S_IDLE:    seg_reg <= seven_seg(4'd0);
            S_ENTRY:   seg_reg <= seven_seg({1'b0, count_reg});
            S_OPEN:    seg_reg <= seven_seg(sec_reg);
            S_LOCKOUT: seg_reg <= seven_seg(sec_reg);
            default:   seg_reg <= seg_reg;
         endcase
      end
   end

   assign keys.unlock = unlock_reg;
   assign keys.alarm  = alarm_reg;
   assign keys.seg    = seg_reg;

endmodule

// File: tb/tb_keypad_code_entry.sv
// Directed bench for keypad_code_entry: debounce, correct code, lockout,
// simultaneous presses, entry timeout and reset during lockout.
module tb_keypad_code_entry;

   localparam logic [6:0] SEG_LUT [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   keypad_code_entry_if bus ();

   keypad_code_entry #(
      .DEBOUNCE_CYCLES(4),
      .TICK_CYCLES    (10),
      .CODE           (8'b01_10_11_01),
      .MAX_FAIL       (3),
      .OPEN_S         (3),
      .LOCKOUT_S      (5),
      .TIMEOUT_S      (4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .keys (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      assert (act === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_seg(input string name, input int d);
      check(name, {1'b0, bus.seg}, {1'b0, SEG_LUT[d]});
   endtask

   task automatic set_btn(input int b, input logic v);
      case (b)
         1: bus.btn1 = v;
         2: bus.btn2 = v;
         default: bus.btn3 = v;
      endcase
   endtask

   // Clean press: display reflects the new entry 8 falling edges after the press starts.
   task automatic press(input int b, input int d, input string name);
      set_btn(b, 1'b0);
      step(8);
      check_seg(name, d);
      set_btn(b, 1'b1);
      step(8);
   endtask

   // Fourth (correct) press and the full open window: unlock high exactly 30 cycles.
   task automatic open_seq(input int b);
      set_btn(b, 1'b0);
      step(7);
      check("unlock_before", {7'd0, bus.unlock}, 8'd0);
      step(1);
      check("unlock_rise", {7'd0, bus.unlock}, 8'd1);
      set_btn(b, 1'b1);
      step(1);
      check_seg("open_seg3", 3);
      step(10);
      check_seg("open_seg2", 2);
      step(10);
      check_seg("open_seg1", 1);
      step(8);
      check("unlock_last", {7'd0, bus.unlock}, 8'd1);
      step(1);
      check("unlock_fall", {7'd0, bus.unlock}, 8'd0);
      step(1);
      check_seg("open_done_seg0", 0);
      check("open_fail_cnt", {5'd0, dut.fail_cnt_reg}, 8'd0);
   endtask

   task automatic wrong_seq(input int k);
      press(3, 1, "wrong_p1");
      press(3, 2, "wrong_p2");
      press(3, 3, "wrong_p3");
      press(3, 3, "wrong_p4_hold");
      check_seg("wrong_idle_seg", 0);
      check("wrong_fail_cnt", {5'd0, dut.fail_cnt_reg}, 8'(k));
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      bus.btn1    = 1'b1;
      bus.btn2    = 1'b1;
      bus.btn3    = 1'b1;
      step(3);
      check_seg("reset_seg", 0);
      check("reset_unlock", {7'd0, bus.unlock}, 8'd0);
      check("reset_alarm", {7'd0, bus.alarm}, 8'd0);
      check("reset_fail_cnt", {5'd0, dut.fail_cnt_reg}, 8'd0);
      rst_n = 1'b1;
      step(10);

      // Bounced first press: 3 low, 1 high, 8 low
      set_btn(1, 1'b0);
      step(3);
      set_btn(1, 1'b1);
      step(1);
      set_btn(1, 1'b0);
      step(7);
      check_seg("bounce_not_yet", 0);
      step(1);
      check_seg("bounce_accepted", 1);
      step(4);
      set_btn(1, 1'b1);
      step(8);
      check("bounce_single_event", {5'd0, dut.count_reg}, 8'd1);

      press(2, 2, "code_p2");
      press(3, 3, "code_p3");
      open_seq(1);

      // Three wrong entries lead to lockout
      wrong_seq(1);
      wrong_seq(2);
      press(3, 1, "lock_p1");
      press(3, 2, "lock_p2");
      press(3, 3, "lock_p3");
      set_btn(3, 1'b0);
      step(8);
      check("alarm_before", {7'd0, bus.alarm}, 8'd0);
      step(1);
      check("alarm_rise", {7'd0, bus.alarm}, 8'd1);
      set_btn(3, 1'b1);
      step(1);
      check_seg("lock_seg5", 5);
      step(10);
      check_seg("lock_seg4", 4);
      set_btn(1, 1'b0);
      step(10);
      check_seg("lock_seg3_press_ignored", 3);
      check("lock_count_ignored", {5'd0, dut.count_reg}, 8'd0);
      set_btn(1, 1'b1);
      step(10);
      check_seg("lock_seg2", 2);
      step(10);
      check_seg("lock_seg1", 1);
      step(8);
      check("alarm_last", {7'd0, bus.alarm}, 8'd1);
      step(1);
      check("alarm_fall", {7'd0, bus.alarm}, 8'd0);
      step(1);
      check_seg("lock_done_seg0", 0);
      check("lock_fail_cleared", {5'd0, dut.fail_cnt_reg}, 8'd0);

      press(1, 1, "after_lock_p1");
      press(2, 2, "after_lock_p2");
      press(3, 3, "after_lock_p3");
      open_seq(1);

      // Simultaneous presses are discarded
      set_btn(1, 1'b0);
      set_btn(2, 1'b0);
      step(10);
      check_seg("simul_seg0", 0);
      check("simul_count", {5'd0, dut.count_reg}, 8'd0);
      set_btn(1, 1'b1);
      set_btn(2, 1'b1);
      step(8);

      // Entry timeout after the second press
      press(1, 1, "tmo_p1");
      press(2, 2, "tmo_p2");
      step(31);
      check_seg("tmo_still_entry", 2);
      step(1);
      check_seg("tmo_idle_seg0", 0);
      check("tmo_count", {5'd0, dut.count_reg}, 8'd0);
      check("tmo_fail_cnt", {5'd0, dut.fail_cnt_reg}, 8'd0);

      // Reset during lockout with a button held across it
      wrong_seq(1);
      wrong_seq(2);
      press(3, 1, "rst_p1");
      press(3, 2, "rst_p2");
      press(3, 3, "rst_p3");
      press(3, 3, "rst_p4");
      check("rst_in_lockout", {7'd0, bus.alarm}, 8'd1);
      set_btn(1, 1'b0);
      step(5);
      rst_n = 1'b0;
      step(1);
      check("rst_alarm", {7'd0, bus.alarm}, 8'd0);
      check_seg("rst_seg", 0);
      check("rst_fail_cnt", {5'd0, dut.fail_cnt_reg}, 8'd0);
      rst_n = 1'b1;
      step(20);
      check_seg("held_no_event_seg", 0);
      check("held_no_event_count", {5'd0, dut.count_reg}, 8'd0);
      set_btn(1, 1'b1);
      step(8);
      press(1, 1, "repress_after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/keypad_code_entry.md
Name: keypad_code_entry

Overview:
Input-side companion to the countdown/7-seg lock display. Takes the three raw active-low push buttons, synchronises and debounces them, and collects a 4-symbol press sequence. Compares the sequence with a parameterised code and drives unlock, alarm and a 7-segment digit. Repeated failures trigger a timed lockout.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a new button level (20 ms at 50 MHz)
TICK_CYCLES, 50_000_000, clock cycles per one-second tick
CODE, 8'b01_10_11_01, 4 symbols of 2 bits, first symbol in [7:6]; 1=btn1, 2=btn2, 3=btn3; 00 is illegal
MAX_FAIL, 3, wrong entries that trigger lockout (1..7)
OPEN_S, 5, seconds unlock stays high (1..9)
LOCKOUT_S, 9, lockout duration in seconds (1..9)
TIMEOUT_S, 4, idle seconds allowed between presses during entry (1..9)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
btn1  in  1  raw button, active-low, asynchronous to clk
btn2  in  1  raw button, active-low
btn3  in  1  raw button, active-low
unlock  out  1  high while in OPEN
alarm  out  1  high while in LOCKOUT
seg  out  7  active-low 7-seg {g..a}: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000

Behaviour:
- Reset: the only clock is clk. Reset is synchronous and active-low on rst_n. All state is sampled at posedge clk when rst_n=0.
- Reset values: state=IDLE, unlock=0, alarm=0, seg=1000000, fail_cnt=0, entry count=0, debounced levels=1 (released), tick counter=0.
- Input path: 2-FF synchroniser per button, then a per-button counter. The debounced level takes a new synchronised value only after it differs for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts that counter.
- Press event: one-cycle pulse on a debounced 1->0 transition. Releases produce no event.
- Simultaneous events: if 2+ press events occur in the same cycle, all are discarded. No entry is stored and the timeout is not restarted.
- Tick: single-cycle pulse when the tick counter reaches TICK_CYCLES-1, then wraps to 0. The counter restarts at 0 on entry to OPEN or LOCKOUT, and on every accepted press.
- IDLE: seg shows 0. An accepted press stores symbol 0, sets count=1 and moves to ENTRY.
- ENTRY: seg shows count (1..3).
  - Accepted press stores the symbol at position count and increments count.
  - When the 4th symbol is stored, go to CHECK on the next cycle.
  - Timeout: if TIMEOUT_S ticks pass with no accepted press, clear count and go to IDLE. fail_cnt is unchanged.
- CHECK (1 cycle): compare the stored 8 bits with CODE.
  - Match: fail_cnt=0, load the second counter with OPEN_S, go to OPEN.
  - Mismatch: go to FAIL.
  - unlock therefore rises exactly 2 cycles after the 4th press event.
- FAIL (1 cycle): fail_cnt+1.
  - If the new value equals MAX_FAIL, load LOCKOUT_S and go to LOCKOUT.
  - Otherwise go to IDLE.
  - count is cleared in both cases.
- OPEN: unlock=1, seg shows remaining seconds. Each tick decrements the counter. At the tick that takes it to 0, go to IDLE; unlock falls that cycle. Presses are ignored. Duration is exactly OPEN_S*TICK_CYCLES cycles.
- LOCKOUT: alarm=1, seg shows remaining seconds, presses ignored. The final tick returns the block to IDLE with fail_cnt=0.
- Button held through a state change: no new event is produced until it is released and pressed again.
- Reset mid-operation: at the next clock edge every register returns to its reset value. A lockout cannot be bypassed except by reset.
- seg is registered and updates one cycle after a state or count change.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, TICK_CYCLES=10, CODE=01_10_11_01, MAX_FAIL=3, OPEN_S=3, LOCKOUT_S=5, TIMEOUT_S=4.
- Debounce: btn1 low for 3 cycles, high 1, low 8 -> exactly one press event, accepted only after 4 stable low cycles; seg goes 1000000 -> 1111001.
- Correct code: press btn1, btn2, btn3, btn1 (clean presses) -> unlock=1 two cycles after the 4th event; seg shows 3,2,1; unlock low after exactly 30 cycles; fail_cnt=0.
- Lockout: three wrong sequences (btn3 x4) -> after the 3rd, alarm=1 and seg counts 5..1; alarm=0 after 50 cycles; correct code then opens.
- Simultaneous presses: btn1 and btn2 debounced-low in the same cycle -> no entry, seg stays 0, state stays IDLE. Entry timeout: two presses then idle for 40 cycles -> IDLE, seg=0.
- Reset mid-lockout: rst_n=0 for 1 cycle during LOCKOUT -> next edge alarm=0, seg=1000000, fail_cnt=0. Held button across reset produces no event until re-pressed.
